// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: minimum synchroniser depth,
// debounce counter sizing and the edge-pulse encoding.
package button_cond_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned level/pulse outputs for all channels.
interface button_conditioner_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (output button, input level, input rise, input fall);
  modport slave  (input button, output level, output rise, output fall);
endinterface

// File: rtl/button_channel.sv
// One input channel: metastability synchroniser, stability debounce filter,
// debounced level and registered single-cycle rise/fall pulses.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_LEVEL     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("button_channel: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("button_channel: DEBOUNCE_CYCLES must be >= 1");
  end
  if (RESET_LEVEL != 0 && RESET_LEVEL != 1) begin : g_bad_rst
    $error("button_channel: RESET_LEVEL must be 0 or 1");
  end

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           RST_LVL  = 1'(RESET_LEVEL);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  edge_e                  edge_q, edge_d;
  logic                   sync;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], button};
    sync    = sync_q[SYNC_STAGES-1];
    level_d = level_q;
    cnt_d   = '0;
    edge_d  = EDGE_NONE;
    // Any return of sync to the current level leaves cnt_d at zero.
    if (sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync;
        edge_d  = sync ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= {SYNC_STAGES{RST_LVL}};
      cnt_q   <= '0;
      level_q <= RST_LVL;
      edge_q  <= EDGE_NONE;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  assign level = level_q;
  assign rise  = (edge_q == EDGE_RISE);
  assign fall  = (edge_q == EDGE_FALL);

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button/switch conditioner: an array of independent
// button_channel instances behind the board inputs.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = MIN_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_LEVEL     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  if (CHANNELS < 1) begin : g_bad_ch
    $error("button_conditioner: CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0] level_w, rise_w, fall_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .button (bus.button[i]),
      .level  (level_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  assign bus.level = level_w;
  assign bus.rise  = rise_w;
  assign bus.fall  = fall_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a default 2-channel instance and a
// 4-channel, 3-stage, unfiltered instance sharing one clock.
module tb_button_conditioner;

  typedef struct packed {
    logic [3:0] lv;
    logic [3:0] rs;
    logic [3:0] fl;
  } exp_t;

  logic clk;
  logic rst1_n;
  logic rst2_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  button_conditioner_if #(.CHANNELS(2)) if1 ();
  button_conditioner_if #(.CHANNELS(4)) if2 ();

  button_conditioner #(
    .CHANNELS        (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (0)
  ) dut1 (
    .clk   (clk),
    .reset (rst1_n),
    .bus   (if1)
  );

  button_conditioner #(
    .CHANNELS        (4),
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1),
    .RESET_LEVEL     (0)
  ) dut2 (
    .clk   (clk),
    .reset (rst2_n),
    .bus   (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0] lv, input logic [3:0] rs,
                          input logic [3:0] fl, input int n);
    for (int i = 0; i < n; i++) sb.push_back(exp_t'({lv, rs, fl}));
  endtask

  task automatic test_reset();
    exp_t e, o;
    int   k;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    if1.button = 2'b11;
    if2.button = 4'b0000;
    #1;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    #1;
    checks++;
    if ({if1.level, if1.rise, if1.fall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: level=%b rise=%b fall=%b expected all 0",
               if1.level, if1.rise, if1.fall);
    end
    @(negedge clk);
    push_exp(4'b0000, 4'b0000, 4'b0000, 3);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      if (k == 3) rst1_n = 1'b1;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
    push_exp(4'b0000, 4'b0000, 4'b0000, 5);
    push_exp(4'b0011, 4'b0011, 4'b0000, 1);
    push_exp(4'b0011, 4'b0000, 4'b0000, 2);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_release edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  task automatic test_fall_both();
    exp_t e, o;
    int   k;
    if1.button = 2'b00;
    push_exp(4'b0011, 4'b0000, 4'b0000, 5);
    push_exp(4'b0000, 4'b0000, 4'b0011, 1);
    push_exp(4'b0000, 4'b0000, 4'b0000, 2);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fall_both edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  task automatic test_rise_ch0();
    exp_t e, o;
    int   k;
    if1.button = 2'b01;
    push_exp(4'b0000, 4'b0000, 4'b0000, 5);
    push_exp(4'b0001, 4'b0001, 4'b0000, 1);
    push_exp(4'b0001, 4'b0000, 4'b0000, 4);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rise_ch0 edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e, o;
    int   k;
    if1.button = 2'b00;
    push_exp(4'b0001, 4'b0000, 4'b0000, 5);
    push_exp(4'b0000, 4'b0000, 4'b0001, 1);
    push_exp(4'b0000, 4'b0000, 4'b0000, 2);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL glitch_setup edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
    if1.button = 2'b01;
    push_exp(4'b0000, 4'b0000, 4'b0000, 12);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      if (k == 3) if1.button = 2'b00;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL glitch_reject edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  task automatic test_bounce_ch1();
    exp_t       e, o;
    int         k;
    logic [0:8] pat;
    pat = 9'b1_0110_1111;
    if1.button = {pat[0], 1'b0};
    push_exp(4'b0000, 4'b0000, 4'b0000, 10);
    push_exp(4'b0010, 4'b0010, 4'b0000, 1);
    push_exp(4'b0010, 4'b0000, 4'b0000, 3);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      if (k < 9) if1.button = {pat[k], 1'b0};
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_ch1 edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    int   k;
    if1.button = 2'b11;
    push_exp(4'b0010, 4'b0000, 4'b0000, 4);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midcount_pre edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
    rst1_n = 1'b0;
    #1;
    checks++;
    if ({if1.level, if1.rise, if1.fall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_midcount: level=%b rise=%b fall=%b expected all 0",
               if1.level, if1.rise, if1.fall);
    end
    @(negedge clk);
    rst1_n = 1'b1;
    push_exp(4'b0000, 4'b0000, 4'b0000, 5);
    push_exp(4'b0011, 4'b0011, 4'b0000, 1);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL recount edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
    rst1_n = 1'b0;
    #1;
    checks++;
    if ({if1.level, if1.rise, if1.fall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_midpulse: level=%b rise=%b fall=%b expected all 0",
               if1.level, if1.rise, if1.fall);
    end
    if1.button = 2'b00;
    @(negedge clk);
    rst1_n = 1'b1;
    push_exp(4'b0000, 4'b0000, 4'b0000, 8);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({2'b00, if1.level, 2'b00, if1.rise, 2'b00, if1.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset_quiet edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  task automatic test_no_filter();
    exp_t e, o;
    int   k;
    checks++;
    if ({if2.level, if2.rise, if2.fall} !== 12'b0) begin
      errors++;
      $display("FAIL nf_reset: level=%b rise=%b fall=%b expected all 0",
               if2.level, if2.rise, if2.fall);
    end
    if2.button = 4'b0000;
    rst2_n = 1'b1;
    cycle();
    cycle();
    if2.button = 4'b1010;
    push_exp(4'b0000, 4'b0000, 4'b0000, 3);
    push_exp(4'b1010, 4'b1010, 4'b0000, 1);
    push_exp(4'b1010, 4'b0000, 4'b0000, 2);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({if2.level, if2.rise, if2.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nf_rise edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
    if2.button = 4'b0000;
    push_exp(4'b1010, 4'b0000, 4'b0000, 3);
    push_exp(4'b0000, 4'b0000, 4'b1010, 1);
    push_exp(4'b0000, 4'b0000, 4'b0000, 2);
    k = 0;
    while (sb.size() > 0) begin
      cycle();
      k++;
      e = sb.pop_front();
      o = exp_t'({if2.level, if2.rise, if2.fall});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nf_fall edge%0d: got l=%b r=%b f=%b want l=%b r=%b f=%b",
                 k, o.lv, o.rs, o.fl, e.lv, e.rs, e.fl);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fall_both();
    test_rise_ch0();
    test_glitch();
    test_bounce_ch1();
    test_async_reset();
    test_no_filter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
